hw_barrier_initiator: RTL and testbench
=======================================

# hw_barrier_initiator

Bus-master sequencer that drives the peripheral-bus port of the hardware barrier unit on behalf of one requester (a core-side accelerator or a DMA-style controller). It turns single commands (setup masks, arrive, arrive-and-wait, read status) into the required register writes and reads, with one transaction outstanding at a time. It also captures the barrier event returned by the barrier unit and reports completion on a simple valid/ready command/response pair.

## Interface
Parameters:
- NB_CORES, 4, width of all trigger/target/status masks
- BASE_ADDR, 32'h0000_0000, byte base address of the barrier unit register block
- TIMEOUT_CYCLES, 1024, wait-for-event watchdog limit; used only with the timeout macro

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_op_i  in  2  00 SETUP, 01 ARRIVE_WAIT, 10 ARRIVE, 11 READ_STATUS
- cmd_trig_mask_i  in  NB_CORES  trigger mask (SETUP) or arrive bits (ARRIVE*)
- cmd_target_mask_i  in  NB_CORES  target mask (SETUP only)
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_data_o  out  NB_CORES  status read data (READ_STATUS), else 0
- rsp_err_o  out  1  timeout flag, qualified by rsp_valid_o
- barrier_event_i  in  1  barrier event bit for this requester's target core
- req_o / add_o[31:0] / wen_o / wdata_o[31:0] / be_o[3:0]  out  master request side; wen_o=1 read, 0 write
- gnt_i  in  1  grant
- r_valid_i  in  1  response valid, the cycle after grant
- r_rdata_i  in  32  read data

## Operation
- Register offsets from BASE_ADDR: 0x00 trigger mask, 0x04 status, 0x0C target mask, 0x10 trigger.
- FSM states: IDLE, WR_TMASK, WR_GMASK, WR_ARRIVE, RD_STAT, RSP_WAIT, WAIT_EVT, DONE.
- IDLE:
  - cmd_ready_o=1.
  - On accept, latch operands and op.
  - SETUP→WR_TMASK, ARRIVE*→WR_ARRIVE, READ_STATUS→RD_STAT.
- Each bus state:
  - Asserts req_o with stable add_o, wen_o and wdata_o (mask zero-extended), with be_o=4'hF.
  - Holds the request until gnt_i, then moves to RSP_WAIT.
  - Stalls with gnt_i=0 (write conflict at the barrier unit) are legal and unbounded.
- RSP_WAIT completes on r_valid_i, then:
  - After WR_TMASK → WR_GMASK.
  - After WR_GMASK → DONE.
  - After RD_STAT → DONE, with rsp_data_o=r_rdata_i[NB_CORES-1:0] registered.
  - After WR_ARRIVE → WAIT_EVT (ARRIVE_WAIT) or DONE (ARRIVE).
- Event capture:
  - Sticky evt_seen flag is cleared on accept of ARRIVE_WAIT.
  - It is set by barrier_event_i in any cycle from the WR_ARRIVE grant cycle onward.
  - The barrier event is a single-cycle pulse that can coincide with r_valid_i of the arrive write; it must not be lost.
- WAIT_EVT: leaves to DONE when evt_seen or barrier_event_i is set.
- DONE: rsp_valid_o=1 for exactly one cycle, then IDLE.
- barrier_event_i is ignored outside an ARRIVE_WAIT command.

## Timing
- Reset values:
  - state IDLE.
  - req_o, wen_o, rsp_valid_o, rsp_err_o = 0.
  - add_o, wdata_o, be_o, rsp_data_o = 0.
  - cmd_ready_o = 1.
- Per transaction: at least 2 cycles (request with grant, then response). No back-to-back requests, because req_o is low in RSP_WAIT.
- Zero-wait latency from accept to rsp_valid_o:
  - READ_STATUS: 3 cycles.
  - ARRIVE: 3 cycles.
  - SETUP: 5 cycles.
  - ARRIVE_WAIT: 3 cycles plus event wait.
- r_valid_i outside RSP_WAIT is ignored.
- Reset mid-operation: rst_i forces IDLE at the next edge and req_o drops that edge. A late r_valid_i is ignored, and no rsp_valid_o is produced for the aborted command.
- If barrier_event_i and r_valid_i of the arrive write coincide, the FSM passes through WAIT_EVT for one cycle only.

## Configuration
- HW_BARRIER_INITIATOR_TIMEOUT_EN:
  - Defined:
    - A counter (width $clog2(TIMEOUT_CYCLES+1)) clears on entry to WAIT_EVT and increments each cycle there.
    - When it reaches TIMEOUT_CYCLES without an event, go to DONE with rsp_err_o=1.
    - An event arriving in the same cycle takes priority (rsp_err_o=0).
  - Undefined: WAIT_EVT waits indefinitely, rsp_err_o is tied 0 and no counter is instantiated.

## Test plan
- SETUP trig=4'b0011, target=4'b0011, gnt always 1 → write 0x3 to 0x00, then 0x3 to 0x0C; rsp_valid_o 5 cycles after accept.
- READ_STATUS while responder returns 0x5 → read at 0x04 with wen_o=1; rsp_data_o=4'b0101.
- ARRIVE_WAIT bits=4'b0001 with gnt_i low 3 cycles → req_o and add_o=0x10 held stable; barrier_event_i pulse in the same cycle as r_valid_i → rsp_valid_o next-but-one cycle, rsp_err_o=0.
- ARRIVE_WAIT with event 20 cycles later, then rst_i asserted mid-wait on a second command → first completes; second produces no response, and req_o=0 after the reset edge.
- Timeout macro defined, TIMEOUT_CYCLES=8, no event → rsp_valid_o with rsp_err_o=1 after 8 WAIT_EVT cycles. Repeat with the event on cycle 8 → rsp_err_o=0.

Source files
------------

// File: rtl/hw_barrier_initiator.sv
// Bus-master sequencer for the hardware barrier unit: one command in, one bus transaction at a time.
// Optional wait-for-event watchdog is enabled with `define HW_BARRIER_INITIATOR_TIMEOUT_EN.
module hw_barrier_initiator #(
  parameter int          NB_CORES       = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [1:0]          cmd_op_i,
  input  logic [NB_CORES-1:0] cmd_trig_mask_i,
  input  logic [NB_CORES-1:0] cmd_target_mask_i,
  output logic                rsp_valid_o,
  output logic [NB_CORES-1:0] rsp_data_o,
  output logic                rsp_err_o,
  input  logic                barrier_event_i,
  output logic                req_o,
  output logic [31:0]         add_o,
  output logic                wen_o,
  output logic [31:0]         wdata_o,
  output logic [3:0]          be_o,
  input  logic                gnt_i,
  input  logic                r_valid_i,
  input  logic [31:0]         r_rdata_i,
  output logic [2:0]          dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE, WR_TMASK, WR_GMASK, WR_ARRIVE, RD_STAT, RSP_WAIT, WAIT_EVT, DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_SETUP, OP_ARRIVE_WAIT, OP_ARRIVE, OP_READ_STATUS
  } op_t;

  state_t              state, next_state, prev_bus;
  op_t                 op_q;
  logic [NB_CORES-1:0] trig_q, target_q, data_q;
  logic                err_q, evt_seen, accept, evt_arm, evt_hit, timeout, err_set;

  // Handshake: a command transfers on a cycle where cmd_valid_i && cmd_ready_o;
  // the bus request transfers on req_o && gnt_i and r_valid_i follows one cycle later.
  assign dbg_state_o = state;
  assign rsp_data_o  = data_q;
  assign rsp_err_o   = err_q;

  // The event may arrive from the arrive-write grant onward, including alongside its response.
  assign evt_arm = (op_q == OP_ARRIVE_WAIT) &&
                   (((state == WR_ARRIVE) && gnt_i) || (state == RSP_WAIT) || (state == WAIT_EVT));
  assign evt_hit = evt_seen || barrier_event_i;

`ifdef HW_BARRIER_INITIATOR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || (state != WAIT_EVT)) wait_cnt <= '0;
    else                              wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout = (state == WAIT_EVT) && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  logic unused_rdata;
  assign unused_rdata = ^r_rdata_i[31:NB_CORES];

  always_comb begin
    next_state  = state;
    cmd_ready_o = 1'b0;
    accept      = 1'b0;
    req_o       = 1'b0;
    add_o       = 32'h0;
    wen_o       = 1'b0;
    wdata_o     = 32'h0;
    be_o        = 4'h0;
    rsp_valid_o = 1'b0;
    err_set     = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          accept = 1'b1;
          case (op_t'(cmd_op_i))
            OP_SETUP:       next_state = WR_TMASK;
            OP_READ_STATUS: next_state = RD_STAT;
            default:        next_state = WR_ARRIVE;
          endcase
        end
      end
      WR_TMASK, WR_GMASK, WR_ARRIVE, RD_STAT: begin
        req_o = 1'b1;
        be_o  = 4'hF;
        if (gnt_i) next_state = RSP_WAIT;
        case (state)
          WR_TMASK: begin
            add_o   = BASE_ADDR;
            wdata_o = 32'(trig_q);
          end
          WR_GMASK: begin
            add_o   = BASE_ADDR + 32'h0C;
            wdata_o = 32'(target_q);
          end
          WR_ARRIVE: begin
            add_o   = BASE_ADDR + 32'h10;
            wdata_o = 32'(trig_q);
          end
          default: begin
            add_o = BASE_ADDR + 32'h04;
            wen_o = 1'b1;
          end
        endcase
      end
      RSP_WAIT: begin
        if (r_valid_i) begin
          case (prev_bus)
            WR_TMASK:  next_state = WR_GMASK;
            WR_ARRIVE: next_state = (op_q == OP_ARRIVE_WAIT) ? WAIT_EVT : DONE;
            default:   next_state = DONE;
          endcase
        end
      end
      WAIT_EVT: begin
        if (evt_hit) begin
          next_state = DONE;
        end else if (timeout) begin
          next_state = DONE;
          err_set    = 1'b1;
        end
      end
      DONE: begin
        rsp_valid_o = 1'b1;
        next_state  = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      prev_bus <= IDLE;
      op_q     <= OP_SETUP;
      trig_q   <= '0;
      target_q <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      evt_seen <= 1'b0;
    end else begin
      state <= next_state;
      if (req_o && gnt_i) prev_bus <= state;
      if (accept) begin
        op_q     <= op_t'(cmd_op_i);
        trig_q   <= cmd_trig_mask_i;
        target_q <= cmd_target_mask_i;
        data_q   <= '0;
        err_q    <= 1'b0;
        if (op_t'(cmd_op_i) == OP_ARRIVE_WAIT) evt_seen <= 1'b0;
      end
      if ((state == RSP_WAIT) && r_valid_i && (prev_bus == RD_STAT))
        data_q <= r_rdata_i[NB_CORES-1:0];
      if (evt_arm && barrier_event_i) evt_seen <= 1'b1;
      if (err_set) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hw_barrier_initiator.sv
// Self-checking bench for hw_barrier_initiator: randomized bus responder, timing/transaction model
// computed from command-level rules, directed corner cases plus random commands.
module tb_hw_barrier_initiator;

  localparam int          NB    = 4;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          TO    = 8;
  localparam logic [1:0]  OP_SETUP = 2'b00;
  localparam logic [1:0]  OP_AW    = 2'b01;
  localparam logic [1:0]  OP_ARR   = 2'b10;
  localparam logic [1:0]  OP_RD    = 2'b11;
`ifdef HW_BARRIER_INITIATOR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk, rst_i;
  logic          cmd_valid_i, cmd_ready_o;
  logic [1:0]    cmd_op_i;
  logic [NB-1:0] cmd_trig_mask_i, cmd_target_mask_i;
  logic          rsp_valid_o, rsp_err_o;
  logic [NB-1:0] rsp_data_o;
  logic          barrier_event_i;
  logic          req_o, wen_o, gnt_i, r_valid_i;
  logic [31:0]   add_o, wdata_o, r_rdata_i;
  logic [3:0]    be_o;
  logic [2:0]    dbg_state_o;

  hw_barrier_initiator #(
    .NB_CORES(NB), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_trig_mask_i(cmd_trig_mask_i), .cmd_target_mask_i(cmd_target_mask_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .barrier_event_i(barrier_event_i),
    .req_o(req_o), .add_o(add_o), .wen_o(wen_o), .wdata_o(wdata_o), .be_o(be_o),
    .gnt_i(gnt_i), .r_valid_i(r_valid_i), .r_rdata_i(r_rdata_i),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- responder / scoreboard ----------------
  logic [64:0] exp_q[$];        // {addr, wen, wdata} of each expected bus transaction
  int          stall_q[$];      // grant stall length per upcoming request
  bit          in_req = 1'b0;
  int          stall_left = 0;
  logic [31:0] first_add;
  bit          resp_next = 1'b0, resp_is_read = 1'b0, resp_is_arrive = 1'b0;
  logic [31:0] status_val = 32'h0;
  int          evt_delay = -1;
  int          evt_cnt = -1;
  bit          noise_en = 1'b0;
  int          inject_n = 0;

  always @(negedge clk) begin
    barrier_event_i = 1'b0;
    r_valid_i       = 1'b0;
    r_rdata_i       = $urandom;
    gnt_i           = 1'b0;
    if (resp_next) begin
      r_valid_i = 1'b1;
      if (resp_is_read) r_rdata_i = status_val;
      if (resp_is_arrive && evt_delay >= 0) evt_cnt = evt_delay;
    end
    resp_next = 1'b0;
    if (inject_n > 0) begin
      r_valid_i = 1'b1;
      inject_n--;
    end
    if (evt_cnt == 0) begin
      barrier_event_i = 1'b1;
      evt_cnt = -1;
    end else if (evt_cnt > 0) begin
      evt_cnt--;
    end else if (noise_en && $urandom_range(3) == 0) begin
      barrier_event_i = 1'b1;
    end
    if (in_req && !req_o) in_req = 1'b0;
    if (req_o) begin
      if (!in_req) begin
        in_req     = 1'b1;
        stall_left = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
        first_add  = add_o;
      end
      if (stall_left > 0) begin
        stall_left--;
      end else begin
        gnt_i          = 1'b1;
        in_req         = 1'b0;
        resp_next      = 1'b1;
        resp_is_read   = wen_o;
        resp_is_arrive = !wen_o && (add_o == BASE + 32'h10);
        check("bus_addr_stable", add_o, first_add);
        check("bus_be", be_o, 4'hF);
        if (exp_q.size() == 0) check("bus_unexpected_txn", 1, 0);
        else check("bus_txn", {add_o, wen_o, wdata_o}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_cmd(input logic [1:0] op, input logic [NB-1:0] trig, input logic [NB-1:0] tgt,
                         input int s0, input int s1, input int d, input logic [31:0] st,
                         input int abort_after);
    int            t_acc, t_end, exp_rsp, n;
    bit            got;
    logic          exp_err;
    logic [NB-1:0] exp_data;
    for (int i = 0; i < 64 && evt_cnt >= 0; i++) @(negedge clk);
    noise_en   = (op != OP_AW);
    evt_delay  = d;
    status_val = st;
    case (op)
      OP_SETUP: begin
        exp_q.push_back({BASE, 1'b0, 32'(trig)});
        exp_q.push_back({BASE + 32'h0C, 1'b0, 32'(tgt)});
        stall_q.push_back(s0);
        stall_q.push_back(s1);
        n = 4 + s0 + s1;
      end
      OP_RD: begin
        exp_q.push_back({BASE + 32'h04, 1'b1, 32'h0});
        stall_q.push_back(s0);
        n = 2 + s0;
      end
      default: begin
        exp_q.push_back({BASE + 32'h10, 1'b0, 32'(trig)});
        stall_q.push_back(s0);
        n = 2 + s0;
      end
    endcase
    cmd_op_i          = op;
    cmd_trig_mask_i   = trig;
    cmd_target_mask_i = tgt;
    cmd_valid_i       = 1'b1;
    check("cmd_ready_idle", cmd_ready_o, 1);
    t_acc = cyc;
    @(negedge clk);
    cmd_valid_i       = 1'b0;
    cmd_op_i          = 2'($urandom);
    cmd_trig_mask_i   = NB'($urandom);
    cmd_target_mask_i = NB'($urandom);
    check("cmd_ready_busy", cmd_ready_o, 0);
    if (abort_after >= 0) begin
      repeat (abort_after) @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      check("req_after_rst", req_o, 0);
      check("state_after_rst", dbg_state_o, 0);
      check("ready_after_rst", cmd_ready_o, 1);
      exp_q.delete();
      stall_q.delete();
      evt_cnt  = -1;
      inject_n = 2;
      got = 1'b0;
      for (int i = 0; i < 12; i++) begin
        if (rsp_valid_o) got = 1'b1;
        @(negedge clk);
      end
      check("no_rsp_after_abort", got, 0);
      return;
    end
    t_end    = t_acc + n;
    exp_err  = 1'b0;
    exp_data = (op == OP_RD) ? st[NB-1:0] : '0;
    if (op == OP_AW) begin
      if (d < 0 || (TO_EN && d > TO)) begin
        exp_rsp = t_end + 1 + TO;
        exp_err = 1'b1;
      end else begin
        exp_rsp = (d <= 1) ? t_end + 2 : t_end + d + 1;
      end
    end else begin
      exp_rsp = t_end + 1;
    end
    for (int i = 0; i < 600 && !rsp_valid_o; i++) @(negedge clk);
    if (!rsp_valid_o) begin
      check("rsp_arrives", 0, 1);
      return;
    end
    check("rsp_cycle", cyc, exp_rsp);
    check("rsp_data", rsp_data_o, exp_data);
    check("rsp_err", rsp_err_o, exp_err);
    @(negedge clk);
    check("rsp_one_cycle", rsp_valid_o, 0);
    check("bus_all_done", exp_q.size(), 0);
  endtask

  function automatic int rand_stall();
    return ($urandom_range(3) == 0) ? int'($urandom_range(6)) : int'($urandom_range(1));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0] op;
    rst_i             = 1'b1;
    cmd_valid_i       = 1'b0;
    cmd_op_i          = 2'b00;
    cmd_trig_mask_i   = '0;
    cmd_target_mask_i = '0;
    repeat (3) @(negedge clk);
    check("rst_req", req_o, 0);
    check("rst_wen", wen_o, 0);
    check("rst_add", add_o, 0);
    check("rst_wdata", wdata_o, 0);
    check("rst_be", be_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rsp_err", rsp_err_o, 0);
    check("rst_rsp_data", rsp_data_o, 0);
    check("rst_ready", cmd_ready_o, 1);
    check("rst_state", dbg_state_o, 0);
    rst_i = 1'b0;
    @(negedge clk);

    run_cmd(OP_SETUP, 4'b0011, 4'b0011, 0, 0, -1, 32'h0, -1);
    run_cmd(OP_RD, 4'b0000, 4'b0000, 0, 0, -1, 32'h0000_0005, -1);
    run_cmd(OP_ARR, 4'b0100, 4'b0000, 0, 0, -1, 32'h0, -1);
    run_cmd(OP_AW, 4'b0001, 4'b0000, 3, 0, 0, 32'h0, -1);
    run_cmd(OP_AW, 4'b0010, 4'b0000, 0, 0, 1, 32'h0, -1);
    run_cmd(OP_AW, 4'b0001, 4'b0000, 0, 0, 20, 32'h0, -1);
    run_cmd(OP_AW, 4'b0001, 4'b0000, 0, 0, -1, 32'h0, 5);
    run_cmd(OP_RD, 4'b0000, 4'b0000, 6, 0, -1, 32'hFFFF_FFFF, 2);
    run_cmd(OP_AW, 4'b1000, 4'b0000, 0, 0, 8, 32'h0, -1);
`ifdef HW_BARRIER_INITIATOR_TIMEOUT_EN
    run_cmd(OP_AW, 4'b1000, 4'b0000, 0, 0, -1, 32'h0, -1);
    run_cmd(OP_AW, 4'b1000, 4'b0000, 1, 0, 9, 32'h0, -1);
`endif
    run_cmd(OP_ARR, 4'b0001, 4'b0000, 2, 0, 0, 32'h0, -1);
    run_cmd(OP_RD, 4'b0000, 4'b0000, 1, 0, -1, 32'hABCD_123A, -1);

    for (int k = 0; k < 40; k++) begin
      op = 2'($urandom);
      run_cmd(op, NB'($urandom), NB'($urandom), rand_stall(), rand_stall(),
              int'($urandom_range(12)), $urandom, -1);
    end

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
